// File: rtl/adc_muestreo.sv
// rtl/adc_muestreo.sv - periodic AD7476-style SPI sampler producing a signed fixed-point sample and strobe
// Optional macro ADC_FILT2_EN: output is the two-tap average of the current and previous samples.
module adc_muestreo #(
   parameter int size       = 19,
   parameter int SHIFT      = 6,
   parameter int CLK_DIV    = 4,
   parameter int SAMPLE_DIV = 1000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   run,
   input  logic                   miso,
   output logic                   sclk,
   output logic                   cs_n,
   output logic signed [size-1:0] yk,
   output logic [11:0]            raw,
   output logic                   sample_en,
   output logic                   overrun
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CONV = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [HW-1:0] HP_LAST   = HW'(CLK_DIV - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);

   logic [1:0]            state_q, state_d;
   logic                  cs_n_q, cs_n_d;
   logic                  sclk_q, sclk_d;
   logic [HW-1:0]         hp_q, hp_d;
   logic [4:0]            bit_q, bit_d;
   logic [15:0]           shift_q, shift_d;
   logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
   logic [11:0]           raw_q, raw_d;
   logic signed [size-1:0] yk_q, yk_d;
   logic                  sample_en_q, sample_en_d;
   logic                  overrun_q, overrun_d;
   logic                  tick_w;
   logic signed [11:0]    centred_w;
   logic signed [size-1:0] cur_w;
`ifdef ADC_FILT2_EN
   logic signed [size-1:0] y_prev_q, y_prev_d;
   logic signed [size:0]   sum_w;
`endif

   assign tick_w = run && (tick_cnt_q == TICK_LAST);

   // Offset binary to two's complement is just an MSB flip.
   assign centred_w = {~shift_q[11], shift_q[10:0]};
   assign cur_w     = {{(size-12){centred_w[11]}}, centred_w} <<< SHIFT;
`ifdef ADC_FILT2_EN
   assign sum_w = {cur_w[size-1], cur_w} + {y_prev_q[size-1], y_prev_q};
`endif

   always_comb begin
      state_d     = state_q;
      cs_n_d      = cs_n_q;
      sclk_d      = sclk_q;
      hp_d        = hp_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      raw_d       = raw_q;
      yk_d        = yk_q;
      sample_en_d = 1'b0;
      overrun_d   = tick_w && (state_q != S_IDLE);
      tick_cnt_d  = '0;
`ifdef ADC_FILT2_EN
      y_prev_d    = y_prev_q;
`endif
      if (run && !tick_w) tick_cnt_d = tick_cnt_q + TW'(1);

      case (state_q)
         S_IDLE: begin
            if (tick_w) begin
               state_d = S_CONV;
               cs_n_d  = 1'b0;
               hp_d    = '0;
               bit_d   = '0;
               shift_d = '0;
            end
         end
         S_CONV: begin
            if (hp_q == HP_LAST) begin
               hp_d = '0;
               // After the 16th rising edge one idle half-period passes before deselect.
               if (bit_q != 5'd16) begin
                  sclk_d = ~sclk_q;
                  if (!sclk_q) begin
                     shift_d = {shift_q[14:0], miso};
                     bit_d   = bit_q + 5'd1;
                  end
               end else begin
                  cs_n_d  = 1'b1;
                  sclk_d  = 1'b1;
                  state_d = S_DONE;
               end
            end else begin
               hp_d = hp_q + HW'(1);
            end
         end
         S_DONE: begin
            state_d     = S_IDLE;
            raw_d       = shift_q[11:0];
            sample_en_d = 1'b1;
`ifdef ADC_FILT2_EN
            yk_d        = sum_w[size:1];
            y_prev_d    = cur_w;
`else
            yk_d        = cur_w;
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cs_n_q      <= 1'b1;
         sclk_q      <= 1'b1;
         hp_q        <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         tick_cnt_q  <= '0;
         raw_q       <= '0;
         yk_q        <= '0;
         sample_en_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef ADC_FILT2_EN
         y_prev_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cs_n_q      <= cs_n_d;
         sclk_q      <= sclk_d;
         hp_q        <= hp_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         tick_cnt_q  <= tick_cnt_d;
         raw_q       <= raw_d;
         yk_q        <= yk_d;
         sample_en_q <= sample_en_d;
         overrun_q   <= overrun_d;
`ifdef ADC_FILT2_EN
         y_prev_q    <= y_prev_d;
`endif
      end
   end

   assign sclk      = sclk_q;
   assign cs_n      = cs_n_q;
   assign yk        = yk_q;
   assign raw       = raw_q;
   assign sample_en = sample_en_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_adc_muestreo.sv
// tb/tb_adc_muestreo.sv - directed self-checking bench for adc_muestreo
// Expected yk values follow ADC_FILT2_EN when the bench is built with that macro.
module tb_adc_muestreo;

`ifdef ADC_FILT2_EN
   localparam logic signed [63:0] E1 = 65504;    // 0xFFF, prev 0
   localparam logic signed [63:0] E2 = 131008;   // 0xFFF, prev 0xFFF
   localparam logic signed [63:0] E3 = -32;      // 0x000
   localparam logic signed [63:0] E4 = -65536;   // 0x800
   localparam logic signed [63:0] E5 = -56224;   // 0x123 after reset
   localparam logic signed [63:0] E6 = -56256;   // 0x7FF after 0x123
   localparam logic signed [63:0] EB = 131008;
`else
   localparam logic signed [63:0] E1 = 131008;
   localparam logic signed [63:0] E2 = 131008;
   localparam logic signed [63:0] E3 = -131072;
   localparam logic signed [63:0] E4 = 0;
   localparam logic signed [63:0] E5 = -112448;
   localparam logic signed [63:0] E6 = -64;
   localparam logic signed [63:0] EB = 131008;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a = 1'b0, run_a = 1'b0, miso_a = 1'b0;
   logic sclk_a, cs_n_a, se_a, ov_a;
   logic signed [18:0] yk_a;
   logic [11:0] raw_a;

   logic rst_b = 1'b0, run_b = 1'b0;
   logic sclk_b, cs_n_b, se_b, ov_b;
   logic signed [18:0] yk_b;
   logic [11:0] raw_b;

   adc_muestreo #(.size(19), .SHIFT(6), .CLK_DIV(4), .SAMPLE_DIV(200)) dut_a (
      .clk(clk), .rst(rst_a), .run(run_a), .miso(miso_a), .sclk(sclk_a), .cs_n(cs_n_a),
      .yk(yk_a), .raw(raw_a), .sample_en(se_a), .overrun(ov_a));

   adc_muestreo #(.size(19), .SHIFT(6), .CLK_DIV(4), .SAMPLE_DIV(100)) dut_b (
      .clk(clk), .rst(rst_b), .run(run_b), .miso(1'b1), .sclk(sclk_b), .cs_n(cs_n_b),
      .yk(yk_b), .raw(raw_b), .sample_en(se_b), .overrun(ov_b));

   // ADC model: 4 leading zeros then 12 bits, one bit per falling sclk.
   logic [11:0] code_a = 12'hFFF;
   logic [15:0] word_a = '0;
   int bit_idx_a = 15;
   always @(negedge cs_n_a) begin
      word_a = {4'b0000, code_a};
      bit_idx_a = 15;
   end
   always @(negedge sclk_a) begin
      if (!cs_n_a && bit_idx_a >= 0) begin
         miso_a = word_a[bit_idx_a];
         bit_idx_a--;
      end
   end

   int cyc = 0;
   int fall_a = 0, last_fall_a = 0, rise_a = 0, hi_run_a = 0, hi_len_a = 0, hi_bad_a = 0;
   int se_cnt_a = 0, last_se_a = 0, prev_se_a = 0, se_rise_a = 0, ov_cnt_a = 0;
   logic cs_prev_a = 1'b1, sclk_prev_a = 1'b1;
   int fall_b = 0, last_fall_b = 0, se_cnt_b = 0, last_se_b = 0, prev_se_b = 0;
   int ov_cnt_b = 0, ov_hi_b = 0, last_ov_b = 0;
   logic cs_prev_b = 1'b1, ov_prev_b = 1'b0;

   always @(posedge clk) begin
      #1;
      cyc++;
      if (cs_prev_a && !cs_n_a) begin
         fall_a++;
         last_fall_a = cyc;
         rise_a = 0;
      end
      if (!cs_n_a && sclk_a && !sclk_prev_a) rise_a++;
      if (!cs_n_a && sclk_a) hi_run_a++;
      else begin
         if (!cs_n_a && sclk_prev_a) begin
            hi_len_a = hi_run_a;
            if (hi_run_a != 4) hi_bad_a++;
         end
         hi_run_a = 0;
      end
      if (se_a) begin
         se_cnt_a++;
         prev_se_a = last_se_a;
         last_se_a = cyc;
         se_rise_a = rise_a;
      end
      if (ov_a) ov_cnt_a++;
      cs_prev_a = cs_n_a;
      sclk_prev_a = sclk_a;

      if (cs_prev_b && !cs_n_b) begin
         fall_b++;
         last_fall_b = cyc;
      end
      if (se_b) begin
         se_cnt_b++;
         prev_se_b = last_se_b;
         last_se_b = cyc;
      end
      if (ov_b) begin
         ov_hi_b++;
         if (!ov_prev_b) begin
            ov_cnt_b++;
            last_ov_b = cyc;
         end
      end
      cs_prev_b = cs_n_b;
      ov_prev_b = ov_b;
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_se_a(input string tag, input int limit);
      int start = se_cnt_a;
      int n = 0;
      while (se_cnt_a == start && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(tag, se_cnt_a - start, 1);
   endtask

   initial begin
      int n;
      int sb, fb;

      repeat (3) @(negedge clk);
      check("rst_cs_n", cs_n_a, 1);
      check("rst_sclk", sclk_a, 1);
      check("rst_yk", yk_a, 0);
      check("rst_raw", raw_a, 0);
      check("rst_sample_en", se_a, 0);
      check("rst_overrun", ov_a, 0);

      rst_a = 1'b1; run_a = 1'b1;
      rst_b = 1'b1; run_b = 1'b1;

      wait_se_a("frame1_strobe", 500);
      check("frame1_raw", raw_a, 12'hFFF);
      check("frame1_yk", yk_a, E1);
      check("latency_tick_to_strobe", last_se_a - (last_fall_a - 1), 134);
      check("sclk_rises_per_frame", se_rise_a, 16);
      check("sclk_high_time", hi_len_a, 4);

      wait_se_a("frame2_strobe", 400);
      check("strobe_period", last_se_a - prev_se_a, 200);
      check("frame2_yk", yk_a, E2);
      code_a = 12'h000;
      repeat (50) @(negedge clk);
      check("yk_held", yk_a, E2);

      wait_se_a("frame3_strobe", 400);
      check("code000_raw", raw_a, 12'h000);
      check("code000_yk", yk_a, E3);
      code_a = 12'h800;

      wait_se_a("frame4_strobe", 400);
      check("code800_raw", raw_a, 12'h800);
      check("code800_yk", yk_a, E4);
      code_a = 12'h123;

      n = 0;
      while (!(rise_a == 8 && !cs_n_a) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("reach_8th_rise", rise_a, 8);
      sb = se_cnt_a;
      rst_a = 1'b0;
      #1;
      check("midrst_cs_n", cs_n_a, 1);
      check("midrst_sclk", sclk_a, 1);
      check("midrst_yk", yk_a, 0);
      check("midrst_raw", raw_a, 0);
      repeat (20) @(negedge clk);
      check("midrst_no_strobe", se_cnt_a, sb);
      rst_a = 1'b1;
      wait_se_a("post_rst_strobe", 600);
      check("post_rst_raw", raw_a, 12'h123);
      check("post_rst_yk", yk_a, E5);
      check("post_rst_latency", last_se_a - last_fall_a, 133);

      code_a = 12'h7FF;
      fb = fall_a;
      n = 0;
      while (fall_a == fb && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("rundrop_frame_start", fall_a - fb, 1);
      repeat (30) @(negedge clk);
      run_a = 1'b0;
      wait_se_a("rundrop_strobe", 300);
      check("rundrop_raw", raw_a, 12'h7FF);
      check("rundrop_yk", yk_a, E6);
      fb = fall_a;
      sb = se_cnt_a;
      repeat (600) @(negedge clk);
      check("rundrop_no_cs_fall", fall_a, fb);
      check("rundrop_no_strobe", se_cnt_a, sb);
      check("a_no_overrun", ov_cnt_a, 0);
      check("a_sclk_high_all", hi_bad_a, 0);

      sb = se_cnt_b;
      n = 0;
      while (se_cnt_b == sb && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("b_strobe_seen", se_cnt_b - sb, 1);
      check("b_enough_frames", (se_cnt_b >= 5) ? 1 : 0, 1);
      check("b_overrun_per_frame", ov_cnt_b, se_cnt_b);
      check("b_overrun_one_cycle", ov_hi_b, ov_cnt_b);
      check("b_overrun_timing", last_ov_b - last_fall_b, 100);
      check("b_frame_period", last_se_b - prev_se_b, 200);
      check("b_raw", raw_b, 12'hFFF);
      check("b_yk", yk_b, EB);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
